// File: rtl/grid_pkg.sv
// grid_pkg: shared types, default field layout and helper functions
// for the grid ingress path.
//   - DEF_* : default packet field positions and sizes
//   - *_WIDTH : field widths derived from the defaults
//   - row_state_e : per-row occupancy tracking state
//   - field_width / field_clear_mask : helpers used to slice and rewrite fields
package grid_pkg;

    localparam int STATS_WIDTH   = 16;
    localparam int MAX_PKT_WIDTH = 64;

    localparam int DEF_DX_MSB    = 29;
    localparam int DEF_DX_LSB    = 21;
    localparam int DEF_DY_MSB    = 20;
    localparam int DEF_DY_LSB    = 12;
    localparam int DEF_NUM_AXONS = 256;
    localparam int DEF_NUM_TICKS = 16;

    typedef logic [MAX_PKT_WIDTH-1:0] wide_pkt_t;

    typedef enum logic [1:0] {
        ROW_EMPTY   = 2'd0,
        ROW_PARTIAL = 2'd1,
        ROW_FULL    = 2'd2
    } row_state_e;

    function automatic int field_width(input int msb, input int lsb);
        return msb - lsb + 1;
    endfunction

    localparam int DX_WIDTH   = field_width(DEF_DX_MSB, DEF_DX_LSB);
    localparam int DY_WIDTH   = field_width(DEF_DY_MSB, DEF_DY_LSB);
    localparam int AXON_WIDTH = $clog2(DEF_NUM_AXONS);
    localparam int TICK_WIDTH = $clog2(DEF_NUM_TICKS);

    // AND-mask that zeroes bits [msb:lsb] and keeps every other bit; used to
    // clear the dy field of a packet on entry.
    function automatic wide_pkt_t field_clear_mask(input int msb, input int lsb);
        wide_pkt_t m;
        m = '0;
        for (int i = 0; i < MAX_PKT_WIDTH; i++) begin
            if ((i >= lsb) && (i <= msb)) begin
                m[i] = 1'b0;
            end else begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/ingress_fifo.sv
// ingress_fifo: show-ahead single-clock FIFO for one grid row.
//   clk, rst_n   : clock, asynchronous active-low reset
//   push/wr_data : write port (ignored while full)
//   pop          : read strobe (ignored while empty, flagged as underflow)
//   head         : current head entry, 0 when empty
//   count        : number of stored entries
//   empty/full   : decoded from the registered occupancy state
//   underflow    : pop seen while empty (combinational pulse)
module ingress_fifo
    import grid_pkg::*;
#(
    parameter int WIDTH = 30,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             underflow
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    row_state_e       state_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s = push && (state_r != ROW_FULL);
    assign do_pop_s  = pop && (count_r != {CNT_W{1'b0}});
    assign underflow = pop && (count_r == {CNT_W{1'b0}});
    assign count     = count_r;
    assign empty     = (state_r == ROW_EMPTY);
    assign full      = (state_r == ROW_FULL);

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        count_nxt_s = count_r;
        case ({do_push_s, do_pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Show-ahead head: the entry at the read pointer, forced to 0 when empty.
    always_comb begin
        if (state_r == ROW_EMPTY) begin
            head = {WIDTH{1'b0}};
        end else begin
            head = mem_r[rd_ptr_r];
        end
    end

    // Storage array write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers and count; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_nxt_s;
        end
    end

    // Occupancy tracking FSM; a count step is at most one, so FULL never
    // reaches EMPTY in a single cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ROW_EMPTY;
        end else begin
            case (state_r)
                ROW_EMPTY: begin
                    if (count_nxt_s != {CNT_W{1'b0}}) begin
                        state_r <= ROW_PARTIAL;
                    end
                end
                ROW_PARTIAL: begin
                    if (count_nxt_s == {CNT_W{1'b0}}) begin
                        state_r <= ROW_EMPTY;
                    end else if (count_nxt_s == CNT_W'(DEPTH)) begin
                        state_r <= ROW_FULL;
                    end
                end
                ROW_FULL: begin
                    if (count_nxt_s != CNT_W'(DEPTH)) begin
                        state_r <= ROW_PARTIAL;
                    end
                end
                default: state_r <= ROW_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/grid_ingress_router.sv
// grid_ingress_router: steers host packets into one FIFO per grid row so every
// west-edge core injects in parallel. The dy field selects the row and is
// rewritten to zero on entry; packets with an out-of-range dy are discarded.
//   clk, rst_network_n   : clock, asynchronous active-low reset
//   tick                 : grid tick pulse
//   in_valid/in_ready    : host handshake, packet_in is the host packet
//   row_packet/row_empty : per-row FIFO head and empty flag to west-edge cores
//   row_ren              : per-row pop from west-edge cores
//   busy                 : any row FIFO holds data
//   drop_error, underflow_error, tick_overrun_error : sticky error flags
// Optional statistics (macro GRID_INGRESS_STATS_EN): row_accept_count and
// drop_count, saturating 16-bit counters cleared by a tick while idle.
module grid_ingress_router
    import grid_pkg::*;
#(
    parameter int GRID_DIMENSION_Y = 4,
    parameter int DX_MSB           = DEF_DX_MSB,
    parameter int DX_LSB           = DEF_DX_LSB,
    parameter int DY_MSB           = DEF_DY_MSB,
    parameter int DY_LSB           = DEF_DY_LSB,
    parameter int NUM_AXONS        = DEF_NUM_AXONS,
    parameter int NUM_TICKS        = DEF_NUM_TICKS,
    parameter int PACKET_WIDTH     = field_width(DX_MSB, DX_LSB) + field_width(DY_MSB, DY_LSB)
                                     + $clog2(NUM_AXONS) + $clog2(NUM_TICKS),
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_network_n,
    input  logic                                 tick,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [PACKET_WIDTH-1:0]              packet_in,
    output logic [GRID_DIMENSION_Y*PACKET_WIDTH-1:0] row_packet,
    output logic [GRID_DIMENSION_Y-1:0]          row_empty,
    input  logic [GRID_DIMENSION_Y-1:0]          row_ren,
    output logic                                 busy,
    output logic                                 drop_error,
    output logic                                 underflow_error,
    output logic                                 tick_overrun_error
`ifdef GRID_INGRESS_STATS_EN
    ,
    output logic [GRID_DIMENSION_Y*STATS_WIDTH-1:0] row_accept_count,
    output logic [STATS_WIDTH-1:0]               drop_count
`endif
);

    localparam int DY_W  = field_width(DY_MSB, DY_LSB);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam wide_pkt_t DY_CLR_WIDE = field_clear_mask(DY_MSB, DY_LSB);
    localparam logic [PACKET_WIDTH-1:0] DY_CLR_MASK = DY_CLR_WIDE[PACKET_WIDTH-1:0];

    logic [DY_W-1:0]             dy_s;
    logic                        tgt_valid_s;
    logic [GRID_DIMENSION_Y-1:0] row_sel_s;
    logic [GRID_DIMENSION_Y-1:0] row_full_s;
    logic [GRID_DIMENSION_Y-1:0] row_push_s;
    logic [GRID_DIMENSION_Y-1:0] row_under_s;
    logic [GRID_DIMENSION_Y-1:0] row_nonzero_s;
    logic [CNT_W-1:0]            row_count_s [GRID_DIMENSION_Y];
    logic [PACKET_WIDTH-1:0]     wr_data_s;
    logic                        accept_s;
    logic                        drop_s;
    logic                        drop_error_r;
    logic                        underflow_error_r;
    logic                        tick_overrun_error_r;

    assign dy_s        = packet_in[DY_MSB:DY_LSB];
    // dy is two's complement: negative or too large means no such row.
    assign tgt_valid_s = (dy_s[DY_W-1] == 1'b0) && (dy_s < DY_W'(GRID_DIMENSION_Y));
    assign wr_data_s   = packet_in & DY_CLR_MASK;
    assign accept_s    = in_valid && in_ready;
    assign drop_s      = accept_s && !tgt_valid_s;
    assign row_push_s  = row_sel_s & {GRID_DIMENSION_Y{accept_s}};
    assign busy        = |row_nonzero_s;

    // One-hot row select from the decoded target.
    always_comb begin
        row_sel_s = {GRID_DIMENSION_Y{1'b0}};
        for (int r = 0; r < GRID_DIMENSION_Y; r++) begin
            if (tgt_valid_s && (dy_s == DY_W'(r))) begin
                row_sel_s[r] = 1'b1;
            end else begin
                row_sel_s[r] = 1'b0;
            end
        end
    end

    // Invalid targets are always consumed; valid ones wait on a full row.
    // A same-cycle pop deliberately does not open a full row.
    always_comb begin
        if (!tgt_valid_s) begin
            in_ready = 1'b1;
        end else begin
            in_ready = ~(|(row_sel_s & row_full_s));
        end
    end

    for (genvar g = 0; g < GRID_DIMENSION_Y; g++) begin : g_row
        ingress_fifo #(
            .WIDTH (PACKET_WIDTH),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_network_n),
            .push      (row_push_s[g]),
            .wr_data   (wr_data_s),
            .pop       (row_ren[g]),
            .head      (row_packet[g*PACKET_WIDTH +: PACKET_WIDTH]),
            .count     (row_count_s[g]),
            .empty     (row_empty[g]),
            .full      (row_full_s[g]),
            .underflow (row_under_s[g])
        );
        assign row_nonzero_s[g] = (row_count_s[g] != {CNT_W{1'b0}});
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge rst_network_n) begin
        if (!rst_network_n) begin
            drop_error_r         <= 1'b0;
            underflow_error_r    <= 1'b0;
            tick_overrun_error_r <= 1'b0;
        end else begin
            if (drop_s) begin
                drop_error_r <= 1'b1;
            end
            if (|row_under_s) begin
                underflow_error_r <= 1'b1;
            end
            if (tick && busy) begin
                tick_overrun_error_r <= 1'b1;
            end
        end
    end

    assign drop_error         = drop_error_r;
    assign underflow_error    = underflow_error_r;
    assign tick_overrun_error = tick_overrun_error_r;

`ifdef GRID_INGRESS_STATS_EN
    logic [STATS_WIDTH-1:0] acc_cnt_r [GRID_DIMENSION_Y];
    logic [STATS_WIDTH-1:0] acc_nxt_s [GRID_DIMENSION_Y];
    logic [STATS_WIDTH-1:0] drop_cnt_r;
    logic [STATS_WIDTH-1:0] drop_nxt_s;
    logic [STATS_WIDTH-1:0] base_s;
    logic                   stat_clr_s;

    assign stat_clr_s = tick && !busy;

    // Saturating counter updates; an idle tick clears before this cycle's event adds.
    always_comb begin
        base_s = {STATS_WIDTH{1'b0}};
        for (int r = 0; r < GRID_DIMENSION_Y; r++) begin
            if (stat_clr_s) begin
                base_s = {STATS_WIDTH{1'b0}};
            end else begin
                base_s = acc_cnt_r[r];
            end
            if (row_push_s[r] && (base_s != {STATS_WIDTH{1'b1}})) begin
                acc_nxt_s[r] = base_s + STATS_WIDTH'(1);
            end else begin
                acc_nxt_s[r] = base_s;
            end
        end
        if (stat_clr_s) begin
            base_s = {STATS_WIDTH{1'b0}};
        end else begin
            base_s = drop_cnt_r;
        end
        if (drop_s && (base_s != {STATS_WIDTH{1'b1}})) begin
            drop_nxt_s = base_s + STATS_WIDTH'(1);
        end else begin
            drop_nxt_s = base_s;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_network_n) begin
        if (!rst_network_n) begin
            for (int r = 0; r < GRID_DIMENSION_Y; r++) begin
                acc_cnt_r[r] <= {STATS_WIDTH{1'b0}};
            end
            drop_cnt_r <= {STATS_WIDTH{1'b0}};
        end else begin
            for (int r = 0; r < GRID_DIMENSION_Y; r++) begin
                acc_cnt_r[r] <= acc_nxt_s[r];
            end
            drop_cnt_r <= drop_nxt_s;
        end
    end

    for (genvar g = 0; g < GRID_DIMENSION_Y; g++) begin : g_stat
        assign row_accept_count[g*STATS_WIDTH +: STATS_WIDTH] = acc_cnt_r[g];
    end
    assign drop_count = drop_cnt_r;
`endif

endmodule

// File: tb/tb_grid_ingress_router.sv
// tb_grid_ingress_router: directed scenarios plus a randomized run, all
// compared against a queue-based model of the row FIFOs.
module tb_grid_ingress_router;

    localparam int G  = 4;
    localparam int PW = 30;

    logic            clk = 1'b0;
    logic            rst_network_n;
    logic            tick;
    logic            in_valid;
    logic            in_ready;
    logic [PW-1:0]   packet_in;
    logic [G*PW-1:0] row_packet;
    logic [G-1:0]    row_empty;
    logic [G-1:0]    row_ren;
    logic            busy;
    logic            drop_error;
    logic            underflow_error;
    logic            tick_overrun_error;
`ifdef GRID_INGRESS_STATS_EN
    logic [G*16-1:0] row_accept_count;
    logic [15:0]     drop_count;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [PW-1:0] mq [G][$];
    logic m_drop, m_under, m_over;
    int   m_acc [G];
    int   m_dropc;

    grid_ingress_router dut (
        .clk                (clk),
        .rst_network_n      (rst_network_n),
        .tick               (tick),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .packet_in          (packet_in),
        .row_packet         (row_packet),
        .row_empty          (row_empty),
        .row_ren            (row_ren),
        .busy               (busy),
        .drop_error         (drop_error),
        .underflow_error    (underflow_error),
        .tick_overrun_error (tick_overrun_error)
`ifdef GRID_INGRESS_STATS_EN
        ,
        .row_accept_count   (row_accept_count),
        .drop_count         (drop_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] mkpkt(input int dx, input int dy, input int axon, input int tk);
        logic [8:0] dxv;
        logic [8:0] dyv;
        logic [7:0] av;
        logic [3:0] tv;
        dxv = 9'(dx);
        dyv = 9'(dy);
        av  = 8'(axon);
        tv  = 4'(tk);
        return {dxv, dyv, av, tv};
    endfunction

    function automatic int target_row(input logic [PW-1:0] p);
        int dy;
        dy = int'($signed(p[20:12]));
        if (dy >= 0 && dy < G) return dy;
        return -1;
    endfunction

    function automatic logic m_ready(input logic [PW-1:0] p);
        int t;
        t = target_row(p);
        if (t < 0) return 1'b1;
        return (mq[t].size() < 4);
    endfunction

    function automatic logic m_busy();
        for (int r = 0; r < G; r++) if (mq[r].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [G-1:0] m_empty();
        logic [G-1:0] e;
        for (int r = 0; r < G; r++) e[r] = (mq[r].size() == 0);
        return e;
    endfunction

    function automatic logic [PW-1:0] m_head(input int r);
        if (mq[r].size() == 0) return '0;
        return mq[r][0];
    endfunction

    // Advance the model by one clock with the inputs that were presented.
    task automatic m_step(input logic v, input logic [PW-1:0] p, input logic [G-1:0] ren, input logic tk);
        logic rdy, bsy;
        int t;
        logic [PW-1:0] stored;
        rdy = m_ready(p);
        bsy = m_busy();
        if (tk && bsy) m_over = 1'b1;
        if (tk && !bsy) begin
            for (int r = 0; r < G; r++) m_acc[r] = 0;
            m_dropc = 0;
        end
        for (int r = 0; r < G; r++) begin
            if (ren[r]) begin
                if (mq[r].size() > 0) void'(mq[r].pop_front());
                else m_under = 1'b1;
            end
        end
        if (v && rdy) begin
            t = target_row(p);
            if (t >= 0) begin
                stored = mkpkt(int'(p[29:21]), 0, int'(p[11:4]), int'(p[3:0]));
                mq[t].push_back(stored);
                if (m_acc[t] < 65535) m_acc[t]++;
            end else begin
                m_drop = 1'b1;
                if (m_dropc < 65535) m_dropc++;
            end
        end
    endtask

    // One clock: drive at the falling edge, capture in_ready before the rising edge.
    task automatic cycle(input logic v, input logic [PW-1:0] p, input logic [G-1:0] ren, input logic tk,
                         output logic rdy_dut, output logic rdy_ref);
        in_valid  = v;
        packet_in = p;
        row_ren   = ren;
        tick      = tk;
        #1;
        rdy_dut = in_ready;
        rdy_ref = m_ready(p);
        @(posedge clk);
        m_step(v, p, ren, tk);
        @(negedge clk);
        in_valid = 1'b0;
        row_ren  = '0;
        tick     = 1'b0;
    endtask

    task automatic do_reset();
        rst_network_n = 1'b0;
        in_valid = 1'b0;
        packet_in = '0;
        row_ren = '0;
        tick = 1'b0;
        repeat (2) @(negedge clk);
        for (int r = 0; r < G; r++) begin
            mq[r].delete();
            m_acc[r] = 0;
        end
        m_dropc = 0;
        m_drop = 1'b0;
        m_under = 1'b0;
        m_over = 1'b0;
        rst_network_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (row_empty !== 4'b1111) begin
            errors++; $display("FAIL reset_row_empty: got %b expected 1111", row_empty);
        end
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_ready_busy: got ready=%b busy=%b expected 1 0", in_ready, busy);
        end
        checks++;
        if ({drop_error, underflow_error, tick_overrun_error} !== 3'b000 || row_packet !== '0) begin
            errors++; $display("FAIL reset_errors_packets: got err=%b%b%b pkt=%h expected 000 0",
                               drop_error, underflow_error, tick_overrun_error, row_packet);
        end
    endtask

    task automatic test_single();
        logic rd, rr;
        cycle(1'b1, mkpkt(3, 2, 8'h15, 5), 4'b0000, 1'b0, rd, rr);
        checks++;
        if (rd !== 1'b1) begin
            errors++; $display("FAIL single_ready: got %b expected 1", rd);
        end
        checks++;
        if (row_empty !== 4'b1011) begin
            errors++; $display("FAIL single_row_empty: got %b expected 1011", row_empty);
        end
        checks++;
        if (row_packet[2*PW +: PW] !== mkpkt(3, 0, 8'h15, 5)) begin
            errors++; $display("FAIL single_head: got %h expected %h", row_packet[2*PW +: PW], mkpkt(3, 0, 8'h15, 5));
        end
        cycle(1'b0, '0, 4'b0100, 1'b0, rd, rr);
        checks++;
        if (row_empty !== 4'b1111 || underflow_error !== 1'b0) begin
            errors++; $display("FAIL single_pop: got empty=%b uf=%b expected 1111 0", row_empty, underflow_error);
        end
    endtask

    task automatic test_back_to_back();
        logic rd, rr;
        logic [PW-1:0] p [5];
        for (int i = 0; i < 5; i++) p[i] = mkpkt(i + 1, 1, i * 7 + 1, i);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, p[i], 4'b0000, 1'b0, rd, rr);
            checks++;
            if (rd !== 1'b1) begin
                errors++; $display("FAIL b2b_accept_%0d: got ready=%b expected 1", i, rd);
            end
        end
        cycle(1'b1, p[4], 4'b0000, 1'b0, rd, rr);
        checks++;
        if (rd !== 1'b0) begin
            errors++; $display("FAIL b2b_full_ready: got %b expected 0", rd);
        end
        cycle(1'b1, p[4], 4'b0010, 1'b0, rd, rr);
        checks++;
        if (rd !== 1'b0) begin
            errors++; $display("FAIL b2b_no_bypass: got %b expected 0", rd);
        end
        cycle(1'b1, p[4], 4'b0000, 1'b0, rd, rr);
        checks++;
        if (rd !== 1'b1) begin
            errors++; $display("FAIL b2b_fifth_accept: got %b expected 1", rd);
        end
        for (int i = 1; i < 5; i++) begin
            checks++;
            if (row_packet[1*PW +: PW] !== mkpkt(i + 1, 0, i * 7 + 1, i)) begin
                errors++; $display("FAIL b2b_order_%0d: got %h expected %h", i, row_packet[1*PW +: PW], mkpkt(i + 1, 0, i * 7 + 1, i));
            end
            cycle(1'b0, '0, 4'b0010, 1'b0, rd, rr);
        end
        checks++;
        if (row_empty !== 4'b1111 || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_drained: got empty=%b busy=%b expected 1111 0", row_empty, busy);
        end
    endtask

    task automatic test_stats();
`ifdef GRID_INGRESS_STATS_EN
        logic rd, rr;
        cycle(1'b0, '0, 4'b0000, 1'b1, rd, rr);
        checks++;
        if (row_accept_count !== '0 || drop_count !== 16'd0) begin
            errors++; $display("FAIL stats_clear0: got %h %h expected 0 0", row_accept_count, drop_count);
        end
        for (int i = 0; i < 3; i++) cycle(1'b1, mkpkt(i, 0, i, i), 4'b0000, 1'b0, rd, rr);
        checks++;
        if (row_accept_count[15:0] !== 16'd3) begin
            errors++; $display("FAIL stats_row0: got %0d expected 3", row_accept_count[15:0]);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 4'b0001, 1'b0, rd, rr);
        cycle(1'b0, '0, 4'b0000, 1'b1, rd, rr);
        checks++;
        if (row_accept_count[15:0] !== 16'd0 || tick_overrun_error !== 1'b0) begin
            errors++; $display("FAIL stats_tick_clear: got cnt=%0d ovr=%b expected 0 0", row_accept_count[15:0], tick_overrun_error);
        end
`endif
    endtask

    task automatic test_drop();
        logic rd, rr;
        checks++;
        if (drop_error !== 1'b0) begin
            errors++; $display("FAIL drop_initial: got %b expected 0", drop_error);
        end
        cycle(1'b1, mkpkt(1, 4, 2, 3), 4'b0000, 1'b0, rd, rr);
        checks++;
        if (rd !== 1'b1 || drop_error !== 1'b1) begin
            errors++; $display("FAIL drop_dy4: got ready=%b drop=%b expected 1 1", rd, drop_error);
        end
        cycle(1'b1, mkpkt(1, -1, 2, 3), 4'b0000, 1'b0, rd, rr);
        checks++;
        if (rd !== 1'b1 || row_empty !== 4'b1111) begin
            errors++; $display("FAIL drop_dyneg: got ready=%b empty=%b expected 1 1111", rd, row_empty);
        end
    endtask

    task automatic test_underflow();
        logic rd, rr;
        checks++;
        if (underflow_error !== 1'b0) begin
            errors++; $display("FAIL underflow_initial: got %b expected 0", underflow_error);
        end
        cycle(1'b0, '0, 4'b0001, 1'b0, rd, rr);
        checks++;
        if (underflow_error !== 1'b1 || row_empty !== 4'b1111) begin
            errors++; $display("FAIL underflow_set: got uf=%b empty=%b expected 1 1111", underflow_error, row_empty);
        end
    endtask

    task automatic test_tick_overrun();
        logic rd, rr;
        cycle(1'b1, mkpkt(7, 3, 8'hA5, 9), 4'b0000, 1'b0, rd, rr);
        checks++;
        if (tick_overrun_error !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL overrun_pre: got ovr=%b busy=%b expected 0 1", tick_overrun_error, busy);
        end
        cycle(1'b0, '0, 4'b0000, 1'b1, rd, rr);
        checks++;
        if (tick_overrun_error !== 1'b1 || row_empty[3] !== 1'b0 || row_packet[3*PW +: PW] !== mkpkt(7, 0, 8'hA5, 9)) begin
            errors++; $display("FAIL overrun_set: got ovr=%b empty3=%b head=%h expected 1 0 %h",
                               tick_overrun_error, row_empty[3], row_packet[3*PW +: PW], mkpkt(7, 0, 8'hA5, 9));
        end
        cycle(1'b0, '0, 4'b1000, 1'b0, rd, rr);
    endtask

    task automatic test_random();
        logic rd, rr;
        logic v, tk;
        logic [G-1:0] ren;
        int sel, dy;
        do_reset();
        checks++;
        if ({drop_error, underflow_error, tick_overrun_error} !== 3'b000) begin
            errors++; $display("FAIL random_reset_sticky: got %b%b%b expected 000", drop_error, underflow_error, tick_overrun_error);
        end
        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 7) dy = int'($urandom_range(0, G - 1));
            else if (sel == 7) dy = G;
            else if (sel == 8) dy = -1;
            else dy = 100;
            v   = ($urandom_range(0, 3) != 0);
            ren = 4'($urandom) & 4'($urandom);
            tk  = ($urandom_range(0, 19) == 0);
            cycle(v, mkpkt(int'($urandom_range(0, 511)), dy, int'($urandom_range(0, 255)), int'($urandom_range(0, 15))),
                  ren, tk, rd, rr);
            checks++;
            if (rd !== rr) begin
                errors++; $display("FAIL random_ready[%0d]: got %b expected %b", n, rd, rr);
            end
            checks++;
            if (row_empty !== m_empty() || busy !== m_busy()) begin
                errors++; $display("FAIL random_empty_busy[%0d]: got %b %b expected %b %b", n, row_empty, busy, m_empty(), m_busy());
            end
            for (int r = 0; r < G; r++) begin
                checks++;
                if (row_packet[r*PW +: PW] !== m_head(r)) begin
                    errors++; $display("FAIL random_head[%0d] row %0d: got %h expected %h", n, r, row_packet[r*PW +: PW], m_head(r));
                end
            end
            checks++;
            if ({drop_error, underflow_error, tick_overrun_error} !== {m_drop, m_under, m_over}) begin
                errors++; $display("FAIL random_errors[%0d]: got %b%b%b expected %b%b%b", n,
                                   drop_error, underflow_error, tick_overrun_error, m_drop, m_under, m_over);
            end
`ifdef GRID_INGRESS_STATS_EN
            for (int r = 0; r < G; r++) begin
                checks++;
                if (row_accept_count[r*16 +: 16] !== 16'(m_acc[r])) begin
                    errors++; $display("FAIL random_acc[%0d] row %0d: got %0d expected %0d", n, r, row_accept_count[r*16 +: 16], m_acc[r]);
                end
            end
            checks++;
            if (drop_count !== 16'(m_dropc)) begin
                errors++; $display("FAIL random_dropc[%0d]: got %0d expected %0d", n, drop_count, m_dropc);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stats();
        test_drop();
        test_underflow();
        test_tick_overrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/grid_ingress_router.md
Name: grid_ingress_router

Overview:
- Successor to the single-port grid input path, where all input packets enter at core 0.
- Takes one host packet stream and steers each packet to the west-edge core of its destination row, so all GRID_DIMENSION_Y rows inject in parallel.
- Holds one FIFO per row, rewrites dy to zero on entry, and reports drop/underflow/tick-overrun errors.
- Sits between the host input buffer and the grid's west-edge router ports (empty/ren/packet handshake).

Parameters:
- GRID_DIMENSION_Y, 4, number of rows and output channels (>=1).
- DX_MSB, 29, dx field MSB.
- DX_LSB, 21, dx field LSB.
- DY_MSB, 20, dy field MSB.
- DY_LSB, 12, dy field LSB; dy is two's complement.
- NUM_AXONS, 256, axon count; sets axon field width.
- NUM_TICKS, 16, tick count; sets tick field width.
- PACKET_WIDTH, (DX_MSB-DX_LSB+1)+(DY_MSB-DY_LSB+1)+$clog2(NUM_AXONS)+$clog2(NUM_TICKS), packet width.
- FIFO_DEPTH, 4, entries per row FIFO; power of two, >=2.

Ports:
- clk  input  1  clock.
- rst_network_n  input  1  asynchronous active-low reset.
- tick  input  1  grid tick pulse.
- in_valid  input  1  host packet valid.
- in_ready  output  1  host packet accepted when in_valid & in_ready.
- packet_in  input  PACKET_WIDTH  host packet.
- row_packet  output  GRID_DIMENSION_Y*PACKET_WIDTH  FIFO head per row; row r at bits [r*PW +: PW].
- row_empty  output  GRID_DIMENSION_Y  per-row empty, to the west-edge core's empty_in_west.
- row_ren  input  GRID_DIMENSION_Y  per-row pop, from the west-edge core's ren_out_west.
- busy  output  1  any row FIFO non-empty.
- drop_error  output  1  sticky: a packet with an out-of-range dy was discarded.
- underflow_error  output  1  sticky: row_ren was asserted on an empty row.
- tick_overrun_error  output  1  sticky: tick arrived while busy.

Behaviour:
- Reset (async, rst_network_n=0):
  - all FIFOs empty; row_empty all 1; row_packet all 0; busy 0; all error flags 0.
  - in_ready is combinational and reflects empty FIFOs after reset.
- Target row:
  - tgt = dy field.
  - Valid iff dy sign bit is 0 and tgt < GRID_DIMENSION_Y.
- in_ready:
  - = 1 if target is invalid.
  - else = (count[tgt] < FIFO_DEPTH).
  - A pop in the same cycle does not make a full FIFO ready (no bypass).
- Accept of a valid target:
  - Writes packet_in with the dy field forced to 0 into FIFO[tgt]; dx, axon and tick fields are unchanged.
  - Latency: 1 cycle. Written at the edge, so row_empty[tgt] falls and row_packet shows the entry the next cycle.
- Accept of an invalid target:
  - Packet is consumed and discarded; drop_error set at the next edge.
- FIFOs are show-ahead: row_packet[r] is always the head entry and is 0 when empty.
- row_ren[r] with count>0: pop at the edge.
- row_ren[r] with count==0: ignored; underflow_error set.
- Simultaneous push and pop on the same row: count unchanged, pointers both advance; correct for count 1..DEPTH-1.
  - With count==0, push plus ren counts as an underflow and the push still lands.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally; count is $clog2(FIFO_DEPTH)+1 bits.
- busy = OR over rows of (count != 0), combinational.
- tick while busy sets tick_overrun_error; FIFOs are not flushed.
- Sticky errors clear only on reset.
- Per-row state machine (tracking only): EMPTY -> PARTIAL -> FULL and back, derived from count.
  - The FULL -> EMPTY transition is impossible in a single cycle.

Optional Feature:
- Macro GRID_INGRESS_STATS_EN.
- When defined:
  - adds output row_accept_count, GRID_DIMENSION_Y*16 bits: per-row 16-bit counters of packets written.
  - counters saturate at 0xFFFF, reset to 0, and are cleared when tick and !busy are both high.
  - adds output drop_count, 16 bits, saturating, same clear rule.
- When undefined: neither port nor counter logic exists; all other behaviour is identical.

Decomposition:
- Package grid_pkg holds:
  - DX_WIDTH, DY_WIDTH, AXON_WIDTH, TICK_WIDTH localparam functions of the field parameters;
  - dy field extract/zero helper function;
  - STATS_WIDTH=16.
- One natural sub-module: ingress_fifo, a show-ahead single-clock FIFO with count output, instantiated GRID_DIMENSION_Y times via generate.

Test Plan:
- Reset, then idle: row_empty=4'b1111, in_ready=1, busy=0, all errors 0.
- Packet dx=3, dy=2, axon=0x15, tick=5, in_valid=1 for 1 cycle.
  - Next cycle: row_empty=4'b1011, row_packet[2] has dx=3, dy=0, axon=0x15, tick=5.
  - After row_ren[2] pulse: row_empty=4'b1111.
- 5 back-to-back packets to row 1 with row_ren=0: first 4 accepted, in_ready=0 on the 5th.
  - row_ren[1] pulse -> 5th accepted the following cycle; FIFO order preserved.
- Packets with dy=4 and dy=-1: both consumed (in_ready=1); drop_error=1; no row_empty change.
- row_ren[0]=1 on empty row 0 -> underflow_error=1.
- tick while row 3 holds 1 entry -> tick_overrun_error=1, entry still present.
- With GRID_INGRESS_STATS_EN defined: 3 packets to row 0 -> row_accept_count[0]=3; tick with busy=0 -> 0.
